// File: rtl/multicycle_ctrl_if.sv
// multicycle_ctrl_if
//   Bundles the instruction fields, ALU flags and datapath control lines
//   exchanged between the multicycle controller and the ARM-subset datapath.
//   master : controller side (takes instruction fields/flags, drives controls)
//   slave  : datapath side (drives instruction fields/flags, takes controls)
interface multicycle_ctrl_if;
  logic [1:0] Op;
  logic [5:0] Funct;
  logic [3:0] Rd;
  logic [3:0] ALUFlags;
  logic       CondEx;
  logic [1:0] FlagA;
  logic [1:0] FlagB;
  logic       PCWrite;
  logic       AdrSrc;
  logic       MemWrite;
  logic       IRWrite;
  logic       RegWrite;
  logic [1:0] ResultSrc;
  logic       ALUSrcA;
  logic [1:0] ALUSrcB;
  logic [1:0] ALUControl;
  logic [3:0] State;
  logic       Illegal;

  modport master (
    input  Op, Funct, Rd, ALUFlags, CondEx,
    output FlagA, FlagB, PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite,
           ResultSrc, ALUSrcA, ALUSrcB, ALUControl, State, Illegal
  );

  modport slave (
    output Op, Funct, Rd, ALUFlags, CondEx,
    input  FlagA, FlagB, PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite,
           ResultSrc, ALUSrcA, ALUSrcB, ALUControl, State, Illegal
  );
endinterface

// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl
//   Multicycle control FSM for the ARM-subset core: sequences fetch, decode,
//   memory, ALU and branch steps, decodes ALUControl/FlagW, holds the N/Z/C/V
//   flag registers and gates architectural writes with the registered CondEx.
// Ports
//   clk   : rising-edge clock
//   reset : synchronous, active-high
//   bus   : multicycle_ctrl_if.master (instruction fields, ALU flags, CondEx in;
//           FlagA/FlagB, datapath controls, State, Illegal out)
// Parameter
//   MEM_WAIT : extra wait cycles in FETCH and MEMRD for slow memory (0..15)
//
// state  | meaning
// FETCH  | read instruction, PC+4; IR/PC load in last wait cycle
// DECODE | read registers, latch CondEx, dispatch on Op
// MEMADR | compute load/store address
// MEMRD  | read data memory (held MEM_WAIT+1 cycles)
// MEMWB  | write loaded data to register file
// MEMWR  | write data memory
// EXECR  | ALU op with register operand
// EXECI  | ALU op with immediate operand
// ALUWB  | write ALU result to register file
// BRANCH | compute branch target, load PC
module multicycle_ctrl #(
  parameter int unsigned MEM_WAIT = 0
) (
  input  logic              clk,
  input  logic              reset,
  multicycle_ctrl_if.master bus
);

  typedef enum logic [3:0] {
    FETCH  = 4'd0,
    DECODE = 4'd1,
    MEMADR = 4'd2,
    MEMRD  = 4'd3,
    MEMWB  = 4'd4,
    MEMWR  = 4'd5,
    EXECR  = 4'd6,
    EXECI  = 4'd7,
    ALUWB  = 4'd8,
    BRANCH = 4'd9
  } state_t;

  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b01;
  localparam logic [1:0] ALU_AND = 2'b10;
  localparam logic [1:0] ALU_ORR = 2'b11;
  localparam logic [3:0] WAIT_LAST = 4'(MEM_WAIT);

  state_t     state, nextState;
  logic [3:0] waitCnt;
  logic       condExR;
  logic [1:0] flagA, flagB;

  logic       waitDone, fetchLast, regW, memW, branch, isExec, illegal;
  logic       noWrite, flagS;
  logic [1:0] aluDec, aluCtl, flagW;
  logic       regWriteG;

  // Funct is held stable by the IR for the whole instruction, so the decode
  // is also valid in ALUWB where NoWrite suppresses the CMP write-back.
  always_comb begin
    aluDec  = ALU_ADD;
    noWrite = 1'b0;
    flagS   = bus.Funct[0];
    case (bus.Funct[4:1])
      4'b0100: aluDec = ALU_ADD;
      4'b0010: aluDec = ALU_SUB;
      4'b0000: aluDec = ALU_AND;
      4'b1100: aluDec = ALU_ORR;
      4'b1010: begin
        aluDec  = ALU_SUB;
        noWrite = 1'b1;
        flagS   = 1'b1;
      end
      default: aluDec = ALU_ADD;
    endcase
  end

  assign flagW    = {flagS, flagS & ((aluDec == ALU_ADD) | (aluDec == ALU_SUB))};
  assign waitDone = (waitCnt == WAIT_LAST);

  always_comb begin
    nextState     = state;
    fetchLast     = 1'b0;
    regW          = 1'b0;
    memW          = 1'b0;
    branch        = 1'b0;
    isExec        = 1'b0;
    illegal       = 1'b0;
    aluCtl        = ALU_ADD;
    bus.AdrSrc    = 1'b0;
    bus.ResultSrc = 2'b00;
    bus.ALUSrcA   = 1'b0;
    bus.ALUSrcB   = 2'b00;
    case (state)
      FETCH: begin
        bus.ALUSrcA   = 1'b1;
        bus.ALUSrcB   = 2'b10;
        bus.ResultSrc = 2'b10;
        if (waitDone) begin
          fetchLast = 1'b1;
          nextState = DECODE;
        end
      end
      DECODE: begin
        bus.ALUSrcA   = 1'b1;
        bus.ALUSrcB   = 2'b10;
        bus.ResultSrc = 2'b10;
        case (bus.Op)
          2'b00:   nextState = bus.Funct[5] ? EXECI : EXECR;
          2'b01:   nextState = MEMADR;
          2'b10:   nextState = BRANCH;
          default: begin
            nextState = FETCH;
            illegal   = 1'b1;
          end
        endcase
      end
      MEMADR: begin
        bus.ALUSrcB = 2'b01;
        nextState   = bus.Funct[0] ? MEMRD : MEMWR;
      end
      MEMRD: begin
        bus.AdrSrc = 1'b1;
        if (waitDone) nextState = MEMWB;
      end
      MEMWB: begin
        bus.ResultSrc = 2'b01;
        regW          = 1'b1;
        nextState     = FETCH;
      end
      MEMWR: begin
        bus.AdrSrc = 1'b1;
        memW       = 1'b1;
        nextState  = FETCH;
      end
      EXECR: begin
        aluCtl    = aluDec;
        isExec    = 1'b1;
        nextState = ALUWB;
      end
      EXECI: begin
        bus.ALUSrcB = 2'b01;
        aluCtl      = aluDec;
        isExec      = 1'b1;
        nextState   = ALUWB;
      end
      ALUWB: begin
        regW      = 1'b1;
        nextState = FETCH;
      end
      BRANCH: begin
        bus.ALUSrcB   = 2'b01;
        bus.ResultSrc = 2'b10;
        branch        = 1'b1;
        nextState     = FETCH;
      end
      default: nextState = FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= FETCH;
      waitCnt <= 4'd0;
      flagA   <= 2'b00;
      flagB   <= 2'b00;
      condExR <= 1'b1;
    end else begin
      state <= nextState;
      if ((state == FETCH || state == MEMRD) && !waitDone)
        waitCnt <= waitCnt + 4'd1;
      else
        waitCnt <= 4'd0;
      if (state == DECODE) condExR <= bus.CondEx;
      if (isExec && condExR) begin
        if (flagW[1]) flagA <= {bus.ALUFlags[2], bus.ALUFlags[3]};
        if (flagW[0]) flagB <= bus.ALUFlags[1:0];
      end
    end
  end

  // Enables are masked while reset is high so an aborted instruction never
  // writes on the reset edge.
  assign regWriteG      = regW & condExR & ~noWrite & ~reset;
  assign bus.RegWrite   = regWriteG;
  assign bus.MemWrite   = memW & condExR & ~reset;
  assign bus.IRWrite    = fetchLast & ~reset;
  assign bus.PCWrite    = ~reset & (fetchLast | (branch & condExR) |
                                    (regWriteG & (bus.Rd == 4'd15)));
  assign bus.ALUControl = aluCtl;
  assign bus.FlagA      = flagA;
  assign bus.FlagB      = flagB;
  assign bus.State      = state;
  assign bus.Illegal    = illegal;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb_multicycle_ctrl
//   Directed bench for multicycle_ctrl: one instance with MEM_WAIT=0 and one
//   with MEM_WAIT=2. The driver pushes hand-computed per-cycle expectations
//   into a queue; the monitor pops and compares on the falling edge.
module tb_multicycle_ctrl;

  logic clk = 1'b0;
  logic reset0 = 1'b1;
  logic reset2 = 1'b1;
  always #5 clk = ~clk;

  multicycle_ctrl_if bus0 ();
  multicycle_ctrl_if bus2 ();

  multicycle_ctrl #(.MEM_WAIT(0)) dut0 (.clk(clk), .reset(reset0), .bus(bus0.master));
  multicycle_ctrl #(.MEM_WAIT(2)) dut2 (.clk(clk), .reset(reset2), .bus(bus2.master));

  typedef struct {
    int          sel;
    string       name;
    logic [15:0] exp;
  } item_t;

  item_t q[$];
  int checks = 0;
  int failures = 0;

  logic [15:0] act0, act2;
  assign act0 = {bus0.State, bus0.IRWrite, bus0.PCWrite, bus0.RegWrite, bus0.MemWrite,
                 bus0.Illegal, bus0.AdrSrc, bus0.ALUControl, bus0.FlagA, bus0.FlagB};
  assign act2 = {bus2.State, bus2.IRWrite, bus2.PCWrite, bus2.RegWrite, bus2.MemWrite,
                 bus2.Illegal, bus2.AdrSrc, bus2.ALUControl, bus2.FlagA, bus2.FlagB};

  // Monitor: fields are {State, IRWrite, PCWrite, RegWrite, MemWrite, Illegal,
  // AdrSrc, ALUControl, FlagA, FlagB}.
  always @(negedge clk) begin
    while (q.size() > 0) begin
      item_t it;
      logic [15:0] act;
      it = q.pop_front();
      act = (it.sel == 0) ? act0 : act2;
      checks++;
      if (act !== it.exp) begin
        failures++;
        $display("FAIL %s: got %b required %b", it.name, act, it.exp);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // en = {IRWrite, PCWrite, RegWrite, MemWrite, Illegal}; flg = {FlagA, FlagB}.
  // AdrSrc is 1 only in MEMRD (3) and MEMWR (5).
  task automatic chk(input int sel, input string nm, input logic [3:0] st,
                     input logic [4:0] en, input logic [1:0] alu, input logic [3:0] flg);
    item_t it;
    it.sel  = sel;
    it.name = nm;
    it.exp  = {st, en, (st == 4'd3 || st == 4'd5), alu, flg};
    q.push_back(it);
  endtask

  task automatic set0(input logic [1:0] op, input logic [5:0] fn, input logic [3:0] rd,
                      input logic [3:0] fl, input logic ce);
    bus0.Op = op; bus0.Funct = fn; bus0.Rd = rd; bus0.ALUFlags = fl; bus0.CondEx = ce;
  endtask

  task automatic set2(input logic [1:0] op, input logic [5:0] fn, input logic [3:0] rd,
                      input logic [3:0] fl, input logic ce);
    bus2.Op = op; bus2.Funct = fn; bus2.Rd = rd; bus2.ALUFlags = fl; bus2.CondEx = ce;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    set0(2'b00, 6'b0, 4'd0, 4'b0, 1'b1);
    set2(2'b00, 6'b0, 4'd0, 4'b0, 1'b1);

    // reset, MEM_WAIT=0
    tick(); chk(0, "rst_a", 4'd0, 5'b00000, 2'b00, 4'b0000);
    tick(); chk(0, "rst_b", 4'd0, 5'b00000, 2'b00, 4'b0000);

    // ADDS imm: FETCH(IR/PC) DECODE EXECI ALUWB
    tick(); reset0 = 1'b0; set0(2'b00, 6'b101001, 4'd1, 4'b0100, 1'b1);
    chk(0, "adds_fetch", 4'd0, 5'b11000, 2'b00, 4'b0000);
    tick(); chk(0, "adds_dec",   4'd1, 5'b00000, 2'b00, 4'b0000);
    tick(); chk(0, "adds_exec",  4'd7, 5'b00000, 2'b00, 4'b0000);
    tick(); chk(0, "adds_wb",    4'd8, 5'b00100, 2'b00, 4'b1000);

    // SUBS reg, flags 0011 -> FlagA=00 FlagB=11
    tick(); set0(2'b00, 6'b000101, 4'd2, 4'b0011, 1'b1);
    chk(0, "subs_fetch", 4'd0, 5'b11000, 2'b00, 4'b1000);
    tick(); chk(0, "subs_dec",   4'd1, 5'b00000, 2'b00, 4'b1000);
    tick(); chk(0, "subs_exec",  4'd6, 5'b00000, 2'b01, 4'b1000);
    tick(); chk(0, "subs_wb",    4'd8, 5'b00100, 2'b00, 4'b0011);

    // ANDS: only FlagA loads
    tick(); set0(2'b00, 6'b000001, 4'd3, 4'b0100, 1'b1);
    chk(0, "ands_fetch", 4'd0, 5'b11000, 2'b00, 4'b0011);
    tick(); chk(0, "ands_dec",   4'd1, 5'b00000, 2'b00, 4'b0011);
    tick(); chk(0, "ands_exec",  4'd6, 5'b00000, 2'b10, 4'b0011);
    tick(); chk(0, "ands_wb",    4'd8, 5'b00100, 2'b00, 4'b1011);

    // CMP: SUB with NoWrite, FlagA=01 FlagB=00
    tick(); set0(2'b00, 6'b010101, 4'd4, 4'b1000, 1'b1);
    chk(0, "cmp_fetch", 4'd0, 5'b11000, 2'b00, 4'b1011);
    tick(); chk(0, "cmp_dec",   4'd1, 5'b00000, 2'b00, 4'b1011);
    tick(); chk(0, "cmp_exec",  4'd6, 5'b00000, 2'b01, 4'b1011);
    tick(); chk(0, "cmp_wb",    4'd8, 5'b00000, 2'b00, 4'b0100);

    // ADDS with CondEx=0: no write, flags kept
    tick(); set0(2'b00, 6'b101001, 4'd5, 4'b1111, 1'b0);
    chk(0, "nc_fetch", 4'd0, 5'b11000, 2'b00, 4'b0100);
    tick(); chk(0, "nc_dec",   4'd1, 5'b00000, 2'b00, 4'b0100);
    tick(); chk(0, "nc_exec",  4'd7, 5'b00000, 2'b00, 4'b0100);
    tick(); chk(0, "nc_wb",    4'd8, 5'b00000, 2'b00, 4'b0100);

    // B not taken (live CondEx flips to 1 in BRANCH, must be ignored)
    tick(); set0(2'b10, 6'b000000, 4'd0, 4'b0000, 1'b0);
    chk(0, "bnt_fetch", 4'd0, 5'b11000, 2'b00, 4'b0100);
    tick(); chk(0, "bnt_dec", 4'd1, 5'b00000, 2'b00, 4'b0100);
    tick(); bus0.CondEx = 1'b1;
    chk(0, "bnt_branch", 4'd9, 5'b00000, 2'b00, 4'b0100);

    // B taken (live CondEx drops to 0 in BRANCH)
    tick(); set0(2'b10, 6'b000000, 4'd0, 4'b0000, 1'b1);
    chk(0, "bt_fetch", 4'd0, 5'b11000, 2'b00, 4'b0100);
    tick(); chk(0, "bt_dec", 4'd1, 5'b00000, 2'b00, 4'b0100);
    tick(); bus0.CondEx = 1'b0;
    chk(0, "bt_branch", 4'd9, 5'b01000, 2'b00, 4'b0100);

    // ADD reg to R15, S=0: PCWrite in ALUWB, flags untouched
    tick(); set0(2'b00, 6'b001000, 4'd15, 4'b1111, 1'b1);
    chk(0, "pc_fetch", 4'd0, 5'b11000, 2'b00, 4'b0100);
    tick(); chk(0, "pc_dec",  4'd1, 5'b00000, 2'b00, 4'b0100);
    tick(); chk(0, "pc_exec", 4'd6, 5'b00000, 2'b00, 4'b0100);
    tick(); chk(0, "pc_wb",   4'd8, 5'b01100, 2'b00, 4'b0100);

    // STR
    tick(); set0(2'b01, 6'b000000, 4'd2, 4'b0000, 1'b1);
    chk(0, "str_fetch", 4'd0, 5'b11000, 2'b00, 4'b0100);
    tick(); chk(0, "str_dec", 4'd1, 5'b00000, 2'b00, 4'b0100);
    tick(); chk(0, "str_adr", 4'd2, 5'b00000, 2'b00, 4'b0100);
    tick(); chk(0, "str_wr",  4'd5, 5'b00010, 2'b00, 4'b0100);

    // STR aborted by reset in MEMWR
    tick(); chk(0, "strr_fetch", 4'd0, 5'b11000, 2'b00, 4'b0100);
    tick(); chk(0, "strr_dec", 4'd1, 5'b00000, 2'b00, 4'b0100);
    tick(); chk(0, "strr_adr", 4'd2, 5'b00000, 2'b00, 4'b0100);
    tick(); reset0 = 1'b1;
    chk(0, "strr_wr_rst", 4'd5, 5'b00000, 2'b00, 4'b0100);

    // back in FETCH after reset, then illegal opcode
    tick(); reset0 = 1'b0; set0(2'b11, 6'b000000, 4'd0, 4'b0000, 1'b1);
    chk(0, "ill_fetch", 4'd0, 5'b11000, 2'b00, 4'b0000);
    tick(); chk(0, "ill_dec",  4'd1, 5'b00001, 2'b00, 4'b0000);
    tick(); chk(0, "ill_back", 4'd0, 5'b11000, 2'b00, 4'b0000);

    // LDR with MEM_WAIT=2
    tick(); chk(2, "ldr_rst", 4'd0, 5'b00000, 2'b00, 4'b0000);
    tick(); reset2 = 1'b0; set2(2'b01, 6'b000001, 4'd3, 4'b0000, 1'b1);
    chk(2, "ldr_f1", 4'd0, 5'b00000, 2'b00, 4'b0000);
    tick(); chk(2, "ldr_f2",  4'd0, 5'b00000, 2'b00, 4'b0000);
    tick(); chk(2, "ldr_f3",  4'd0, 5'b11000, 2'b00, 4'b0000);
    tick(); chk(2, "ldr_dec", 4'd1, 5'b00000, 2'b00, 4'b0000);
    tick(); chk(2, "ldr_adr", 4'd2, 5'b00000, 2'b00, 4'b0000);
    tick(); chk(2, "ldr_rd1", 4'd3, 5'b00000, 2'b00, 4'b0000);
    tick(); chk(2, "ldr_rd2", 4'd3, 5'b00000, 2'b00, 4'b0000);
    tick(); chk(2, "ldr_rd3", 4'd3, 5'b00000, 2'b00, 4'b0000);
    tick(); chk(2, "ldr_wb",  4'd4, 5'b00100, 2'b00, 4'b0000);

    // LDR into R15
    tick(); set2(2'b01, 6'b000001, 4'd15, 4'b0000, 1'b1);
    chk(2, "ldrpc_f1", 4'd0, 5'b00000, 2'b00, 4'b0000);
    tick(); chk(2, "ldrpc_f2",  4'd0, 5'b00000, 2'b00, 4'b0000);
    tick(); chk(2, "ldrpc_f3",  4'd0, 5'b11000, 2'b00, 4'b0000);
    tick(); chk(2, "ldrpc_dec", 4'd1, 5'b00000, 2'b00, 4'b0000);
    tick(); chk(2, "ldrpc_adr", 4'd2, 5'b00000, 2'b00, 4'b0000);
    tick(); chk(2, "ldrpc_rd1", 4'd3, 5'b00000, 2'b00, 4'b0000);
    tick(); chk(2, "ldrpc_rd2", 4'd3, 5'b00000, 2'b00, 4'b0000);
    tick(); chk(2, "ldrpc_rd3", 4'd3, 5'b00000, 2'b00, 4'b0000);
    tick(); chk(2, "ldrpc_wb",  4'd4, 5'b01100, 2'b00, 4'b0000);
    tick(); chk(2, "ldrpc_next", 4'd0, 5'b00000, 2'b00, 4'b0000);

    @(negedge clk);
    #1;
    if (q.size() != 0) begin
      failures++;
      $display("FAIL queue_drain: got %0d pending required 0", q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
